// File: rtl/data_cache_responder_pkg.sv
// Shared definitions for the data-cache responder: FSM encoding, address
// geometry and the word-alignment helper used for backing-memory addresses.
package data_cache_responder_pkg;

    localparam int ADDR_BITS          = 32;
    localparam int WORD_ADDR_BITS     = ADDR_BITS - 2;
    localparam int DEFAULT_INDEX_BITS = 6;

    typedef enum logic [1:0] {
        CACHE_IDLE  = 2'd0,
        CACHE_FILL  = 2'd1,
        CACHE_WRITE = 2'd2,
        CACHE_DONE  = 2'd3
    } cache_state_e;

    function automatic logic [ADDR_BITS-1:0] word_align(input logic [ADDR_BITS-1:0] addr);
        return {addr[ADDR_BITS-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/data_cache_responder_line_array.sv
// Direct-mapped line storage: combinational read port, one synchronous write
// port, and asynchronous clearing of the valid bits.
module data_cache_responder_line_array
    import data_cache_responder_pkg::*;
#(
    parameter int INDEX_BITS  = DEFAULT_INDEX_BITS,
    parameter int TAG_BITS    = WORD_ADDR_BITS - INDEX_BITS,
    parameter bit RESET_CLEAR = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [31:0]           rd_data,
    input  logic                  we,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [31:0]           wr_data,
    input  logic                  set_valid
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]    valid;
    logic [TAG_BITS-1:0] tag_arr  [LINES];
    logic [31:0]         data_arr [LINES];

    generate
        if (RESET_CLEAR) begin : g_valid_clear
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid <= '0;
                end else if (we && set_valid) begin
                    valid[wr_index] <= 1'b1;
                end
            end
        end else begin : g_valid_keep
            always_ff @(posedge clk) begin
                if (we && set_valid) begin
                    valid[wr_index] <= 1'b1;
                end
            end
        end
    endgenerate

    // NOTE: tag/data storage has no reset; valid gating makes its power-up contents irrelevant.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_arr[wr_index]  <= wr_tag;
            data_arr[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tag_arr[rd_index];
    assign rd_data  = data_arr[rd_index];

endmodule

// File: rtl/data_cache_responder.sv
// Write-through, no-write-allocate direct-mapped data cache in front of a
// req/ack backing memory; read hits complete with no stall.
module data_cache_responder
    import data_cache_responder_pkg::*;
#(
    parameter int INDEX_BITS  = DEFAULT_INDEX_BITS,
    parameter bit RESET_CLEAR = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read_en,
    input  logic        write_en,
    input  logic [31:0] EXT_ADDR,
    input  logic [31:0] EXT_MEM_IN,
    output logic [31:0] EXT_MEM_OUT,
    output logic        ext_cache_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    input  logic        mem_ack,
    input  logic [31:0] MEM_RDATA
);

    localparam int TAG_BITS = WORD_ADDR_BITS - INDEX_BITS;

    cache_state_e          state;
    logic [31:0]           fill_reg;
    logic                  pending_read;

    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   tag;
    logic                  line_valid;
    logic [TAG_BITS-1:0]   line_tag;
    logic [31:0]           line_data;
    logic                  hit;

    logic                  arr_we;
    logic                  arr_set_valid;
    logic [31:0]           arr_data;
    logic                  stall_c;
    logic [31:0]           out_c;

    assign index = EXT_ADDR[INDEX_BITS+1:2];
    assign tag   = EXT_ADDR[31:INDEX_BITS+2];
    assign hit   = line_valid && (line_tag == tag);

    data_cache_responder_line_array #(
        .INDEX_BITS  (INDEX_BITS),
        .TAG_BITS    (TAG_BITS),
        .RESET_CLEAR (RESET_CLEAR)
    ) u_lines (
        .clk       (clk),
        .rst_n     (reset),
        .rd_index  (index),
        .rd_valid  (line_valid),
        .rd_tag    (line_tag),
        .rd_data   (line_data),
        .we        (arr_we),
        .wr_index  (index),
        .wr_tag    (tag),
        .wr_data   (arr_data),
        .set_valid (arr_set_valid)
    );

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        arr_we        = 1'b0;
        arr_set_valid = 1'b0;
        arr_data      = MEM_RDATA;
        stall_c       = 1'b0;
        out_c         = '0;
        case (state)
            CACHE_IDLE: begin
                if (write_en) begin
                    stall_c = 1'b1;
                end else if (read_en) begin
                    if (hit) out_c   = line_data;
                    else     stall_c = 1'b1;
                end
            end
            CACHE_FILL: begin
                stall_c       = 1'b1;
                arr_we        = mem_ack;
                arr_set_valid = 1'b1;
            end
            CACHE_WRITE: begin
                // Write-through updates the cached copy only when the line already holds this address.
                stall_c  = 1'b1;
                arr_we   = mem_ack && hit;
                arr_data = MEM_WDATA;
            end
            CACHE_DONE: begin
                out_c = pending_read ? fill_reg : '0;
            end
            default: ;
        endcase
    end

    assign ext_cache_stall = reset && stall_c;
    assign EXT_MEM_OUT     = reset ? out_c : '0;

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= CACHE_IDLE;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            MEM_ADDR     <= '0;
            MEM_WDATA    <= '0;
            fill_reg     <= '0;
            pending_read <= 1'b0;
        end else begin
            case (state)
                CACHE_IDLE: begin
                    if (write_en) begin
                        state        <= CACHE_WRITE;
                        MEM_ADDR     <= word_align(EXT_ADDR);
                        MEM_WDATA    <= EXT_MEM_IN;
                        mem_we       <= 1'b1;
                        mem_req      <= 1'b1;
                        pending_read <= 1'b0;
                    end else if (read_en && !hit) begin
                        state        <= CACHE_FILL;
                        MEM_ADDR     <= word_align(EXT_ADDR);
                        mem_we       <= 1'b0;
                        mem_req      <= 1'b1;
                        pending_read <= 1'b1;
                    end
                end
                CACHE_FILL: begin
                    if (mem_ack) begin
                        fill_reg <= MEM_RDATA;
                        mem_req  <= 1'b0;
                        state    <= CACHE_DONE;
                    end
                end
                CACHE_WRITE: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= CACHE_DONE;
                    end
                end
                CACHE_DONE: state <= CACHE_IDLE;
                default:    state <= CACHE_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_cache_responder.sv
// Self-checking bench for data_cache_responder: scoreboarded CPU accesses
// against a bench-driven backing memory with programmable ack latency.
module tb_data_cache_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        read_en;
    logic        write_en;
    logic [31:0] EXT_ADDR;
    logic [31:0] EXT_MEM_IN;
    logic [31:0] EXT_MEM_OUT;
    logic        ext_cache_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] MEM_ADDR;
    logic [31:0] MEM_WDATA;
    logic        mem_ack;
    logic [31:0] MEM_RDATA;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    data_cache_responder dut (
        .clk             (clk),
        .reset           (reset),
        .read_en         (read_en),
        .write_en        (write_en),
        .EXT_ADDR        (EXT_ADDR),
        .EXT_MEM_IN      (EXT_MEM_IN),
        .EXT_MEM_OUT     (EXT_MEM_OUT),
        .ext_cache_stall (ext_cache_stall),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .MEM_ADDR        (MEM_ADDR),
        .MEM_WDATA       (MEM_WDATA),
        .mem_ack         (mem_ack),
        .MEM_RDATA       (MEM_RDATA)
    );

    // One CPU access held until the stall clears; backing memory acks k cycles after mem_req rises.
    task automatic do_access(input bit is_wr, input bit also_rd, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata, input int k,
                             input bit exp_miss, input logic [31:0] exp_data, input string name);
        int          stalls  = 0;
        int          req_age = -1;
        bit          done    = 1'b0;
        int          exp_stall;
        logic [31:0] exp_addr;
        logic [31:0] exp_out;
        exp_stall = exp_miss ? 2 + k : 0;
        exp_addr  = {addr[31:2], 2'b00};
        @(negedge clk);
        write_en   = is_wr;
        read_en    = !is_wr || also_rd;
        EXT_ADDR   = addr;
        EXT_MEM_IN = wdata;
        exp_q.push_back(is_wr ? 32'h0 : exp_data);
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            if (cyc > 0) @(negedge clk);
            mem_ack = 1'b0;
            #1;
            if (mem_req === 1'b1) begin
                if (req_age < 0) begin
                    req_age = 0;
                    n_checks++;
                    if (MEM_ADDR !== exp_addr)
                        $display("FAIL %s mem_addr: got %h expected %h", name, MEM_ADDR, exp_addr);
                    else n_pass++;
                    n_checks++;
                    if (mem_we !== is_wr)
                        $display("FAIL %s mem_we: got %b expected %b", name, mem_we, is_wr);
                    else n_pass++;
                    if (is_wr) begin
                        n_checks++;
                        if (MEM_WDATA !== wdata)
                            $display("FAIL %s mem_wdata: got %h expected %h", name, MEM_WDATA, wdata);
                        else n_pass++;
                    end
                end else begin
                    req_age++;
                end
                if (req_age == k) begin
                    mem_ack   = 1'b1;
                    MEM_RDATA = rdata;
                end
            end
            if (ext_cache_stall !== 1'b0) stalls++;
            else done = 1'b1;
        end
        exp_out = exp_q.pop_front();
        if (!done) begin
            n_checks++;
            $display("FAIL %s timeout: stall still high after %0d cycles", name, stalls);
        end else begin
            n_checks++;
            if (EXT_MEM_OUT !== exp_out)
                $display("FAIL %s ext_mem_out: got %h expected %h", name, EXT_MEM_OUT, exp_out);
            else n_pass++;
            n_checks++;
            if (stalls != exp_stall)
                $display("FAIL %s stall_cycles: got %0d expected %0d", name, stalls, exp_stall);
            else n_pass++;
            n_checks++;
            if ((req_age >= 0) != exp_miss)
                $display("FAIL %s backing_request: got %b expected %b", name, req_age >= 0, exp_miss);
            else n_pass++;
        end
        @(negedge clk);
        read_en  = 1'b0;
        write_en = 1'b0;
        mem_ack  = 1'b0;
        #1;
        n_checks++;
        if (mem_req !== 1'b0 || ext_cache_stall !== 1'b0)
            $display("FAIL %s idle_after: got req=%b stall=%b expected req=0 stall=0",
                     name, mem_req, ext_cache_stall);
        else n_pass++;
    endtask

    task automatic test_reset;
        reset      = 1'b0;
        read_en    = 1'b1;
        write_en   = 1'b0;
        EXT_ADDR   = 32'h100;
        EXT_MEM_IN = 32'h0;
        mem_ack    = 1'b0;
        MEM_RDATA  = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (ext_cache_stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", ext_cache_stall);
        else n_pass++;
        n_checks++;
        if (EXT_MEM_OUT !== 32'h0) $display("FAIL reset_out: got %h expected 0", EXT_MEM_OUT);
        else n_pass++;
        n_checks++;
        if (mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b expected 0", mem_req);
        else n_pass++;
        n_checks++;
        if (mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b expected 0", mem_we);
        else n_pass++;
        n_checks++;
        if (MEM_ADDR !== 32'h0) $display("FAIL reset_mem_addr: got %h expected 0", MEM_ADDR);
        else n_pass++;
        n_checks++;
        if (MEM_WDATA !== 32'h0) $display("FAIL reset_mem_wdata: got %h expected 0", MEM_WDATA);
        else n_pass++;
        read_en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_read_miss;
        do_access(1'b0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 3, 1'b1, 32'hDEADBEEF, "read_miss");
    endtask

    task automatic test_read_hit;
        do_access(1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 0, 1'b0, 32'hDEADBEEF, "read_hit");
    endtask

    task automatic test_write_hit;
        do_access(1'b1, 1'b0, 32'h100, 32'h12345678, 32'h0, 0, 1'b1, 32'h0, "write_hit");
        do_access(1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 0, 1'b0, 32'h12345678, "read_after_write");
    endtask

    task automatic test_write_miss;
        do_access(1'b1, 1'b0, 32'h200, 32'hCAFEF00D, 32'h0, 1, 1'b1, 32'h0, "write_miss");
        do_access(1'b0, 1'b0, 32'h200, 32'h0, 32'hCAFEF00D, 2, 1'b1, 32'hCAFEF00D, "no_allocate");
    endtask

    task automatic test_alias;
        do_access(1'b0, 1'b0, 32'h100, 32'h0, 32'h11110000, 0, 1'b1, 32'h11110000, "alias_fill_a");
        do_access(1'b0, 1'b0, 32'h200, 32'h0, 32'h22220000, 1, 1'b1, 32'h22220000, "alias_evict_a");
        do_access(1'b0, 1'b0, 32'h100, 32'h0, 32'h33330000, 2, 1'b1, 32'h33330000, "alias_evict_b");
        do_access(1'b0, 1'b0, 32'h104, 32'h0, 32'h44445555, 0, 1'b1, 32'h44445555, "fill_line1");
        do_access(1'b0, 1'b0, 32'h107, 32'h0, 32'h0, 0, 1'b0, 32'h44445555, "byte_offset_hit");
    endtask

    task automatic test_back_to_back;
        // Write and read together: write wins, and the backing address is word-aligned.
        do_access(1'b1, 1'b1, 32'h106, 32'hA5A5A5A5, 32'h0, 1, 1'b1, 32'h0, "write_priority");
        do_access(1'b0, 1'b0, 32'h104, 32'h0, 32'h0, 0, 1'b0, 32'hA5A5A5A5, "hit_after_wr");
        do_access(1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 0, 1'b0, 32'h33330000, "line0_kept");
    endtask

    task automatic test_stray_ack;
        @(negedge clk);
        mem_ack   = 1'b1;
        MEM_RDATA = 32'hFFFF0000;
        #1;
        n_checks++;
        if (ext_cache_stall !== 1'b0 || mem_req !== 1'b0)
            $display("FAIL stray_ack: got stall=%b req=%b expected 0/0", ext_cache_stall, mem_req);
        else n_pass++;
        @(negedge clk);
        mem_ack = 1'b0;
        do_access(1'b0, 1'b0, 32'h104, 32'h0, 32'h0, 0, 1'b0, 32'hA5A5A5A5, "stray_ack_hit");
    endtask

    task automatic test_reset_mid_fill;
        int wait_cyc = 0;
        @(negedge clk);
        read_en  = 1'b1;
        EXT_ADDR = 32'h300;
        mem_ack  = 1'b0;
        #1;
        while (mem_req !== 1'b1 && wait_cyc < 20) begin
            @(negedge clk);
            #1;
            wait_cyc++;
        end
        n_checks++;
        if (mem_req !== 1'b1) $display("FAIL midfill_start: got req=%b expected 1", mem_req);
        else n_pass++;
        @(negedge clk);
        #1;
        n_checks++;
        if (ext_cache_stall !== 1'b1) $display("FAIL midfill_stall: got %b expected 1", ext_cache_stall);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (mem_req !== 1'b0 || ext_cache_stall !== 1'b0 || EXT_MEM_OUT !== 32'h0)
            $display("FAIL midfill_reset: got req=%b stall=%b out=%h expected 0/0/0",
                     mem_req, ext_cache_stall, EXT_MEM_OUT);
        else n_pass++;
        @(negedge clk);
        read_en   = 1'b0;
        reset     = 1'b1;
        mem_ack   = 1'b1;
        MEM_RDATA = 32'hBAD0BAD0;
        #1;
        n_checks++;
        if (mem_req !== 1'b0 || ext_cache_stall !== 1'b0)
            $display("FAIL late_ack: got req=%b stall=%b expected 0/0", mem_req, ext_cache_stall);
        else n_pass++;
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        n_checks++;
        if (mem_req !== 1'b0) $display("FAIL late_ack_after: got req=%b expected 0", mem_req);
        else n_pass++;
        do_access(1'b0, 1'b0, 32'h100, 32'h0, 32'h55556666, 0, 1'b1, 32'h55556666, "post_reset_miss");
        do_access(1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 0, 1'b0, 32'h55556666, "post_reset_hit");
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_read_hit();
        test_write_hit();
        test_write_miss();
        test_alias();
        test_back_to_back();
        test_stray_ack();
        test_reset_mid_fill();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
